// File: rtl/fpalu_pkg.sv
// Shared FP ALU definitions: IEEE 754 single field boundaries, the result
// class flag bit positions, and the buffered result entry layout.
package fpalu_pkg;

  localparam int unsigned FLAG_W   = 4;
  localparam int unsigned FLAG_NAN = 3;
  localparam int unsigned FLAG_INF = 2;
  localparam int unsigned FLAG_ZERO = 1;
  localparam int unsigned FLAG_SUB = 0;

  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned FRAC_MSB = 22;
  localparam int unsigned FRAC_LSB = 0;

  typedef logic [FLAG_W-1:0] fp_flags_t;

  typedef struct packed {
    logic [31:0] result;
    logic        select;
    fp_flags_t   flags;
  } rb_entry_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE 754 single class decode: {nan, inf, zero, subnormal}.
// The sign bit does not affect the class.
module fp_classify
  import fpalu_pkg::*;
(
  input  logic [31:0]       value,
  output logic [FLAG_W-1:0] flags
);

  logic [EXP_MSB-EXP_LSB:0]   exp_f;
  logic [FRAC_MSB-FRAC_LSB:0] frac_f;
  logic                       exp_max;
  logic                       exp_min;
  logic                       frac_nz;
  logic                       unused_sign;

  always_comb begin
    exp_f       = value[EXP_MSB:EXP_LSB];
    frac_f      = value[FRAC_MSB:FRAC_LSB];
    unused_sign = value[SIGN_BIT];
    exp_max     = (exp_f == EXP_ALL_ONES);
    exp_min     = (exp_f == '0);
    frac_nz     = |frac_f;

    flags            = '0;
    flags[FLAG_NAN]  = exp_max && frac_nz;
    flags[FLAG_INF]  = exp_max && !frac_nz;
    flags[FLAG_ZERO] = exp_min && !frac_nz;
    flags[FLAG_SUB]  = exp_min && frac_nz;
  end

endmodule

// File: rtl/fp_result_buffer.sv
// FIFO of FP ALU results tagged with op select and class flags, plus a
// sticky OR of the flags of every accepted result.
module fp_result_buffer
  import fpalu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_result,
  input  logic             in_select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_select,
  output logic [3:0]       out_flags,
  output logic [PTR_W:0]   count,
  output logic [3:0]       sticky_flags,
  input  logic             clear
);

  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  rb_entry_t        mem_q [DEPTH];
  rb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  fp_flags_t        sticky_q, sticky_d;

  fp_flags_t        in_flags;
  rb_entry_t        in_entry;
  rb_entry_t        head;
  logic             push;
  logic             pop;

  fp_classify u_classify (
    .value (in_result),
    .flags (in_flags)
  );

  // Handshake depends only on registered occupancy, never on out_ready.
  always_comb begin
    in_ready  = (count_q != FULL_COUNT);
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;

    head         = mem_q[rd_ptr_q];
    out_result   = head.result;
    out_select   = head.select;
    out_flags    = head.flags;
    count        = count_q;
    sticky_flags = sticky_q;
  end

  always_comb begin
    in_entry.result = in_result;
    in_entry.select = in_select;
    in_entry.flags  = in_flags;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sticky_d = sticky_q;

    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Clear wins over a same-cycle OR-in, so those flags are dropped.
    if (clear) begin
      sticky_d = '0;
    end else if (push) begin
      sticky_d = sticky_q | in_flags;
    end
  end

  // Storage is zeroed on reset so the head outputs read 0 until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sticky_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_fp_result_buffer.sv
// Self-checking bench for fp_result_buffer: directed scenarios followed by
// random traffic, checked against a queue-based reference model.
module tb_fp_result_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_result;
  logic             in_select;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_select;
  logic [3:0]       out_flags;
  logic [PTR_W:0]   count;
  logic [3:0]       sticky_flags;
  logic             clear;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] r;
    logic        s;
    logic [3:0]  f;
  } ent_t;

  ent_t        mq[$];
  logic [3:0]  msticky;
  bit          ever_pushed;
  logic [31:0] fill_vals[4];

  fp_result_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_select    (in_select),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_select   (out_select),
    .out_flags    (out_flags),
    .count        (count),
    .sticky_flags (sticky_flags),
    .clear        (clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ref_flags(logic [31:0] v);
    int unsigned e, f;
    logic [3:0]  r;
    e = (v / 32'd8388608) % 256;
    f = v % 32'd8388608;
    r = 4'b0000;
    if (e == 255 && f != 0) r = 4'b1000;
    if (e == 255 && f == 0) r = 4'b0100;
    if (e == 0 && f == 0)   r = 4'b0010;
    if (e == 0 && f != 0)   r = 4'b0001;
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("sticky", 32'(sticky_flags), 32'(msticky));
    if (mq.size() != 0) begin
      chk("head_result", out_result, mq[0].r);
      chk("head_select", 32'(out_select), 32'(mq[0].s));
      chk("head_flags", 32'(out_flags), 32'(mq[0].f));
    end else if (!ever_pushed) begin
      chk("idle_result", out_result, 32'h0);
      chk("idle_select", 32'(out_select), 32'h0);
      chk("idle_flags", 32'(out_flags), 32'h0);
    end
  endtask

  // One clock: predict from the inputs held across the edge, then compare.
  task automatic tick();
    bit   m_push, m_pop;
    ent_t e;
    m_push = in_valid && (mq.size() < DEPTH);
    m_pop  = out_ready && (mq.size() != 0);
    e.r = in_result;
    e.s = in_select;
    e.f = ref_flags(in_result);
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      msticky     = 4'b0;
      ever_pushed = 1'b0;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back(e);
        ever_pushed = 1'b1;
      end
      if (clear)       msticky = 4'b0;
      else if (m_push) msticky = msticky | e.f;
    end
    check_all();
  endtask

  task automatic drive(logic iv, logic [31:0] res, logic sel, logic ordy, logic clr);
    in_valid  = iv;
    in_result = res;
    in_select = sel;
    out_ready = ordy;
    clear     = clr;
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 5))
      0: v = {v[31], 8'hFF, 23'h0};
      1: v = {v[31], 8'hFF, v[22:1], 1'b1};
      2: v = {v[31], 8'h00, 23'h0};
      3: v = {v[31], 8'h00, v[22:1], 1'b1};
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    fill_vals[0] = 32'h3f800000;
    fill_vals[1] = 32'h40000000;
    fill_vals[2] = 32'h40400000;
    fill_vals[3] = 32'h40800000;
    msticky      = 4'b0;
    ever_pushed  = 1'b0;
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_result", out_result, 32'h0);

    // Classification through the pipeline with a consumer always ready
    drive(1'b1, 32'h7f800000, 1'b1, 1'b1, 1'b0); tick();
    chk("cls_inf", 32'(out_flags), 32'h4);
    drive(1'b1, 32'h7fc00000, 1'b0, 1'b1, 1'b0); tick();
    chk("cls_nan", 32'(out_flags), 32'h8);
    drive(1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0); tick();
    chk("cls_zero", 32'(out_flags), 32'h2);
    drive(1'b1, 32'h00400000, 1'b0, 1'b1, 1'b0); tick();
    chk("cls_sub", 32'(out_flags), 32'h1);
    drive(1'b1, 32'h3f800000, 1'b1, 1'b1, 1'b0); tick();
    chk("cls_norm", 32'(out_flags), 32'h0);
    chk("cls_sticky", 32'(sticky_flags), 32'hF);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0); tick();

    // Fill to full, attempt an overflow push, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fill_vals[i], i[0], 1'b0, 1'b0); tick();
    end
    chk("full_count", 32'(count), 32'h4);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    drive(1'b1, 32'hc0000000, 1'b1, 1'b0, 1'b0); tick();
    chk("full_ignore_count", 32'(count), 32'h4);
    chk("full_head", out_result, 32'h3f800000);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", out_result, fill_vals[i]);
      tick();
    end
    chk("drain_count", 32'(count), 32'h0);

    // Simultaneous push and pop at count 2
    drive(1'b1, 32'h40a00000, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h40c00000, 1'b1, 1'b0, 1'b0); tick();
    chk("pp_pre_count", 32'(count), 32'h2);
    drive(1'b1, 32'h40e00000, 1'b0, 1'b1, 1'b0);
    chk("pp_popped", out_result, 32'h40a00000);
    tick();
    chk("pp_count", 32'(count), 32'h2);
    chk("pp_head", out_result, 32'h40c00000);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
    chk("pp_tail", out_result, 32'h40e00000);
    tick();

    // Pointer wrap: ten push/pop pairs through a depth-4 buffer
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, $urandom, i[0], 1'b1, 1'b0); tick();
      chk("wrap_count", 32'(count), 32'h1);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
    chk("wrap_empty", 32'(count), 32'h0);

    // Reset while three entries are held, with a push pending
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, (i == 0) ? 32'h7f800000 : fill_vals[i], 1'b1, 1'b0, 1'b0); tick();
    end
    chk("pre_rst_count", 32'(count), 32'h3);
    rst = 1'b1;
    drive(1'b1, 32'h00000000, 1'b1, 1'b1, 1'b1); tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_count", 32'(count), 32'h0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
    chk("mid_rst_sticky", 32'(sticky_flags), 32'h0);
    chk("mid_rst_result", out_result, 32'h0);

    // Clear wins over a same-cycle push
    drive(1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
    chk("pre_clear_sticky", 32'(sticky_flags), 32'h2);
    drive(1'b1, 32'h7f800000, 1'b1, 1'b0, 1'b1); tick();
    chk("clear_sticky", 32'(sticky_flags), 32'h0);
    chk("clear_entry_flags", 32'(out_flags), 32'h4);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0); tick();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 3) != 0), rand_fp(), 1'($urandom),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) tick();
    chk("final_count", 32'(count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_result_buffer.md
FP_RESULT_BUFFER -- requirements
Module: fp_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of result entries held; power of two, 2..16.
REQ-002 SHALL have parameter PTR_W, default 2, log2(DEPTH), pointer width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  ALU result present this cycle.
REQ-006 SHALL have port in_ready  output  1  buffer can accept a result.
REQ-007 SHALL have port in_result  input  32  IEEE 754 single result from the FP ALU.
REQ-008 SHALL have port in_select  input  1  op tag of that result (0 multiply, 1 add).
REQ-009 SHALL have port out_valid  output  1  head entry available.
REQ-010 SHALL have port out_ready  input  1  consumer takes head entry.
REQ-011 SHALL have port out_result  output  32  head entry result.
REQ-012 SHALL have port out_select  output  1  head entry op tag.
REQ-013 SHALL have port out_flags  output  4  head entry class {nan, inf, zero, subnormal}.
REQ-014 SHALL have port count  output  PTR_W+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have port sticky_flags  output  4  OR of flags of every accepted result since reset/clear.
REQ-016 SHALL have port clear  input  1  synchronous clear of sticky_flags only.

Function
REQ-017 SHALL accept (push) when in_valid && in_ready at a rising edge; pop when out_valid && out_ready.
REQ-018 SHALL drive in_ready = (count < DEPTH), with no combinational path from out_ready.
REQ-019 SHALL drive out_valid = (count != 0); out_result/out_select/out_flags from registered head entry, stable while out_valid && !out_ready.
REQ-020 SHALL give latency 1: result pushed into an empty buffer at edge N is visible with out_valid high after edge N.
REQ-021 SHALL classify at push from exponent e=in_result[30:23] and fraction f=in_result[22:0]: nan = e==FF && f!=0; inf = e==FF && f==0; zero = e==0 && f==0; subnormal = e==0 && f!=0; all zero for normal values; sign ignored.
REQ-022 SHALL store flags with the entry; flags are not recomputed at pop.
REQ-023 SHALL, on simultaneous push and pop with 0<count<DEPTH, perform both and leave count unchanged.
REQ-024 SHALL ignore push attempts while full (in_valid with in_ready low), no state change; upstream holds data.
REQ-025 SHALL never pop when empty; out_ready while empty has no effect.
REQ-026 SHALL wrap read and write pointers modulo DEPTH; full/empty derived from count, not pointer equality.
REQ-027 SHALL update sticky_flags |= flags of each accepted result; clear has priority over a same-cycle OR-in (cleared value wins, accepted flags lost).
REQ-028 SHALL preserve FIFO order; entries never reordered or dropped.

Reset
REQ-029 SHALL, when rst is high at an edge, set count=0, pointers=0, sticky_flags=0, out_valid=0, in_ready=1; any same-cycle push/pop/clear is discarded.
REQ-030 SHALL drive out_result=0, out_select=0, out_flags=0 after reset until the first push; storage array need not be reset.
REQ-031 SHALL treat reset mid-operation as full flush; buffered entries lost, no partial output.

Structure
REQ-032 SHALL place flag bit indices (NAN=3, INF=2, ZERO=1, SUB=0), EXP_ALL_ONES=8'hFF, and the 32-bit field boundaries in a shared fpalu package.
REQ-033 SHALL implement classification as one sub-module fp_classify (32-bit in, 4-bit flags out, combinational).
REQ-034 SHALL be sized for 120-400 lines of RTL including fp_classify.

Verification
REQ-035 SHALL test classification: push 7f800000, 7fc00000, 00000000, 00400000, 3f800000 with out_ready=1 -> out_flags 0100, 1000, 0010, 0001, 0000; sticky_flags=1111.
REQ-036 SHALL test full: out_ready=0, push 4 values 3f800000..40800000 -> count=4, in_ready=0; 5th push c0000000 ignored; drain yields 4 values in order, count 0.
REQ-037 SHALL test simultaneous push/pop at count=2 -> count stays 2, popped value = oldest, new value at tail.
REQ-038 SHALL test wrap: 10 push/pop pairs with DEPTH=4 -> outputs match inputs in order, tags preserved.
REQ-039 SHALL test reset at count=3 -> next cycle count=0, out_valid=0, in_ready=1, sticky_flags=0.
REQ-040 SHALL test clear with same-cycle push of 7f800000 -> sticky_flags=0000 after edge, entry flags=0100.
